cpu_run_controller: RTL and testbench

//  Parametrised run/reset sequencer for the pipelined RISC-V CPU core. Sits between
//  the system reset and CPU_Top's rst_n.
//  - Holds the CPU in reset for a programmable number of cycles.
//  - Counts run cycles and retired instructions.
//  - Terminates the run on a halt event (ecall/ebreak, exit code), a cycle timeout
//    or, optionally, a no-retire watchdog.
//  - Reports pass/fail status to the bench or to a debug register file.

---
 rtl/cpu_run_controller.sv | 177 +++++++++++++++++
 tb/tb_cpu_run_controller.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_controller.sv
// Run/reset sequencer for the pipelined RISC-V core: holds CPU reset, counts cycles and
// retires, and ends the run on halt or timeout. Define RUN_CTRL_WATCHDOG_EN for the no-retire watchdog.
module cpu_run_controller #(
  parameter int RESET_CYCLES    = 2,
  parameter int MAX_CYCLES      = 15,
  parameter int CNT_W           = 32,
  parameter int CODE_W          = 32,
  parameter int WATCHDOG_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              retire_valid,
  input  logic              halt_valid,
  input  logic [CODE_W-1:0] halt_code,
  output logic              cpu_rst_n,
  output logic              run_active,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_cause,
  output logic [CODE_W-1:0] exit_code,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instret_count,
  output logic [1:0]        fsm_state
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_HALT     = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
  localparam logic [1:0] CAUSE_WATCHDOG = 2'd3;

  typedef enum logic [1:0] {
    S_RESET_HOLD = 2'd0,
    S_RUN        = 2'd1,
    S_DONE_PASS  = 2'd2,
    S_DONE_FAIL  = 2'd3
  } state_t;

  if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
    $error("RESET_CYCLES must be >= 1");
  end
  if (MAX_CYCLES < 1) begin : g_bad_max_cycles
    $error("MAX_CYCLES must be >= 1");
  end
  if (WATCHDOG_CYCLES < 1) begin : g_bad_watchdog_cycles
    $error("WATCHDOG_CYCLES must be >= 1");
  end

  state_t              state, state_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_n;
  logic                cpu_rst_n_n, run_n, done_n, pass_n;
  logic [1:0]          cause_n;
  logic [CODE_W-1:0]   exit_n;
  logic [CNT_W-1:0]    cyc_n, inst_n;
  logic                wd_hit;

`ifdef RUN_CTRL_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  logic [WD_W-1:0] idle_cnt, idle_n;

  // Hit is flagged on the cycle whose idle count would reach WATCHDOG_CYCLES.
  assign wd_hit = (state == S_RUN) && !retire_valid &&
                  (idle_cnt == WD_W'(WATCHDOG_CYCLES - 1));

  always_comb begin
    idle_n = idle_cnt;
    if (restart || (state != S_RUN) || retire_valid) idle_n = '0;
    else                                             idle_n = idle_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_cnt <= '0;
    else     idle_cnt <= idle_n;
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    hold_n      = hold_cnt;
    cpu_rst_n_n = cpu_rst_n;
    run_n       = run_active;
    done_n      = done;
    pass_n      = pass;
    cause_n     = fail_cause;
    exit_n      = exit_code;
    cyc_n       = cycle_count;
    inst_n      = instret_count;
    if (restart) begin
      state_n     = S_RESET_HOLD;
      hold_n      = '0;
      cpu_rst_n_n = 1'b0;
      run_n       = 1'b0;
      done_n      = 1'b0;
      pass_n      = 1'b0;
      cause_n     = CAUSE_NONE;
      exit_n      = '0;
      cyc_n       = '0;
      inst_n      = '0;
    end else begin
      case (state)
        S_RESET_HOLD: begin
          if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) begin
            state_n     = S_RUN;
            hold_n      = '0;
            cpu_rst_n_n = 1'b1;
            run_n       = 1'b1;
          end else begin
            hold_n = hold_cnt + 1'b1;
          end
        end
        S_RUN: begin
          // Retires are counted on every RUN cycle, including the one that ends the run.
          if (retire_valid && (instret_count != {CNT_W{1'b1}}))
            inst_n = instret_count + 1'b1;
          if (halt_valid) begin
            exit_n = halt_code;
            run_n  = 1'b0;
            done_n = 1'b1;
            if (halt_code == '0) begin
              state_n = S_DONE_PASS;
              pass_n  = 1'b1;
            end else begin
              state_n = S_DONE_FAIL;
              cause_n = CAUSE_HALT;
            end
          end else if (wd_hit) begin
            state_n = S_DONE_FAIL;
            run_n   = 1'b0;
            done_n  = 1'b1;
            cause_n = CAUSE_WATCHDOG;
          end else if (cycle_count == CNT_W'(MAX_CYCLES - 1)) begin
            state_n = S_DONE_FAIL;
            run_n   = 1'b0;
            done_n  = 1'b1;
            cause_n = CAUSE_TIMEOUT;
          end else begin
            cyc_n = cycle_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_RESET_HOLD;
      hold_cnt      <= '0;
      cpu_rst_n     <= 1'b0;
      run_active    <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail_cause    <= CAUSE_NONE;
      exit_code     <= '0;
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      state         <= state_n;
      hold_cnt      <= hold_n;
      cpu_rst_n     <= cpu_rst_n_n;
      run_active    <= run_n;
      done          <= done_n;
      pass          <= pass_n;
      fail_cause    <= cause_n;
      exit_code     <= exit_n;
      cycle_count   <= cyc_n;
      instret_count <= inst_n;
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: vector table for run/halt/timeout/restart,
// hand sequences for async reset mid-run and the no-retire watchdog.
module tb_cpu_run_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        restart = 1'b0, retire_valid = 1'b0, halt_valid = 1'b0;
  logic [31:0] halt_code = '0;
  logic        cpu_rst_n, run_active, done, pass;
  logic [1:0]  fail_cause, fsm_state;
  logic [31:0] exit_code, cycle_count, instret_count;

  logic        w_retire = 1'b0;
  logic        w_cpu_rst_n, w_run_active, w_done, w_pass;
  logic [1:0]  w_fail_cause, w_fsm_state;
  logic [31:0] w_exit_code, w_cycle_count, w_instret_count;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic        restart, retire, halt;
    logic [31:0] code;
    logic        rst_n, run, done, pass;
    logic [1:0]  cause;
    logic [31:0] exit_v, cyc, inst;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  cpu_run_controller dut (
    .clk(clk), .rst(rst), .restart(restart), .retire_valid(retire_valid),
    .halt_valid(halt_valid), .halt_code(halt_code), .cpu_rst_n(cpu_rst_n),
    .run_active(run_active), .done(done), .pass(pass), .fail_cause(fail_cause),
    .exit_code(exit_code), .cycle_count(cycle_count), .instret_count(instret_count),
    .fsm_state(fsm_state)
  );

  cpu_run_controller #(.MAX_CYCLES(100), .WATCHDOG_CYCLES(4)) dut_wd (
    .clk(clk), .rst(rst), .restart(1'b0), .retire_valid(w_retire),
    .halt_valid(1'b0), .halt_code(32'h0), .cpu_rst_n(w_cpu_rst_n),
    .run_active(w_run_active), .done(w_done), .pass(w_pass), .fail_cause(w_fail_cause),
    .exit_code(w_exit_code), .cycle_count(w_cycle_count), .instret_count(w_instret_count),
    .fsm_state(w_fsm_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int rs, input int rt, input int h, input int c,
                              input int rn, input int ra, input int d, input int p,
                              input int fc, input int ex, input int cy, input int in);
    vec_t v;
    v.restart = rs[0]; v.retire = rt[0]; v.halt = h[0]; v.code = c;
    v.rst_n = rn[0]; v.run = ra[0]; v.done = d[0]; v.pass = p[0];
    v.cause = fc[1:0]; v.exit_v = ex; v.cyc = cy; v.inst = in;
    return v;
  endfunction

  task automatic chk_outputs(input string tag, input vec_t v);
    logic [1:0] es;
    es = !v.rst_n ? 2'd0 : (v.done ? (v.pass ? 2'd2 : 2'd3) : 2'd1);
    chk({tag, " cpu_rst_n"}, {31'b0, cpu_rst_n}, {31'b0, v.rst_n});
    chk({tag, " run_active"}, {31'b0, run_active}, {31'b0, v.run});
    chk({tag, " done"}, {31'b0, done}, {31'b0, v.done});
    chk({tag, " pass"}, {31'b0, pass}, {31'b0, v.pass});
    chk({tag, " fail_cause"}, {30'b0, fail_cause}, {30'b0, v.cause});
    chk({tag, " exit_code"}, exit_code, v.exit_v);
    chk({tag, " cycle_count"}, cycle_count, v.cyc);
    chk({tag, " instret_count"}, instret_count, v.inst);
    chk({tag, " fsm_state"}, {30'b0, fsm_state}, {30'b0, es});
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    restart = v.restart; retire_valid = v.retire; halt_valid = v.halt; halt_code = v.code;
    @(posedge clk); #1;
    chk_outputs(tag, v);
  endtask

  function automatic void push_hold();
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
  endfunction

  function automatic void push_restart();
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete in time");
    $fatal(1, "global timeout");
  end

  initial begin
    vec_t zero_v;
    int   k;
    // Reset-hold release, then a clean pass run halting at cycle 9.
    push_hold();
    for (int i = 0; i < 9; i++) vecs.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, i + 1, i + 1));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, 1, 1, 0, 0, 9, 10));
    vecs.push_back(mk(0, 1, 1, 5, 1, 0, 1, 1, 0, 0, 9, 10));
    vecs.push_back(mk(0, 1, 1, 5, 1, 0, 1, 1, 0, 0, 9, 10));
    // Restart from DONE held for two cycles.
    push_restart(); push_restart(); push_hold();
    // Timeout with retires on even cycles only.
    for (int i = 0; i < 14; i++)
      vecs.push_back(mk(0, (i % 2 == 0) ? 1 : 0, 0, 0, 1, 1, 0, 0, 0, 0, i + 1, i / 2 + 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 2, 0, 14, 7));
    vecs.push_back(mk(0, 1, 1, 3, 1, 0, 1, 0, 2, 0, 14, 7));
    push_restart(); push_hold();
    // Halt on the timeout cycle wins.
    for (int i = 0; i < 14; i++) vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, i + 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 14, 0));
    push_restart(); push_hold();
    // Nonzero exit code.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, i + 1, i + 1));
    vecs.push_back(mk(0, 1, 1, 32'hDEAD, 1, 0, 1, 0, 1, 32'hDEAD, 3, 4));
    push_restart(); push_hold();
    // Restart in RUN at cycle 5 beats a simultaneous halt.
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, i + 1, i + 1));
    vecs.push_back(mk(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0));
    push_hold();
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, i + 1, i + 1));

    zero_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Power-on reset for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_outputs($sformatf("por%0d", i), zero_v);
    end
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    restart = 1'b0; retire_valid = 1'b0; halt_valid = 1'b0; halt_code = '0;

    // Asynchronous reset mid-RUN clears at once, before any clock edge.
    #3 rst = 1'b1;
    #1 chk_outputs("async_rst", zero_v);
    @(posedge clk); #1;
    chk_outputs("async_rst_hold", zero_v);
    rst = 1'b0;
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst_hold");
    run_vec(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0), "post_rst_run");
    chk("wd_run_start", {31'b0, w_run_active}, 32'd1);

    // No-retire watchdog: retires on cycles 0..3 only.
    k = 0;
    while (!w_done && k < 150) begin
      w_retire = (k < 4);
      @(posedge clk); #1;
      k++;
    end
    w_retire = 1'b0;
    chk("wd_done", {31'b0, w_done}, 32'd1);
    chk("wd_pass", {31'b0, w_pass}, 32'd0);
    chk("wd_instret", w_instret_count, 32'd4);
    chk("wd_cpu_rst_n", {31'b0, w_cpu_rst_n}, 32'd1);
`ifdef RUN_CTRL_WATCHDOG_EN
    chk("wd_cause", {30'b0, w_fail_cause}, 32'd3);
    chk("wd_cycle", w_cycle_count, 32'd7);
`else
    chk("wd_cause", {30'b0, w_fail_cause}, 32'd2);
    chk("wd_cycle", w_cycle_count, 32'd99);
`endif
    chk("wd_exit_code", w_exit_code, 32'd0);
    chk("wd_state", {30'b0, w_fsm_state}, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
